// File: rtl/tb_sched.sv
// tb_sched: prescaling time base with run / fast-set / pause control.
// Divides clk by DIV (normal) or FAST_DIV (fast set) and emits a
// one-cycle clock-enable pulse on every wrap of the prescale counter.
// Ports:
//   clk   in   master clock, everything changes on the rising edge
//   rst   in   asynchronous active-high reset
//   run   in   1 = count, 0 = pause
//   fast  in   1 = use FAST_DIV while running
//   clr   in   synchronous clear, highest priority
//   tick  out  one-cycle enable pulse per counter wrap (registered)
//   f100  out  square wave toggling on every tick (registered)
//   state out  IDLE=00 RUN=01 FAST=10 PAUSE=11 (registered)
//   cnt   out  current prescale count (registered)
//   busy  out  state is RUN or FAST
module tb_sched #(
    parameter int DIV      = 1000,
    parameter int FAST_DIV = 10,
    parameter int W        = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         fast,
    input  logic         clr,
    output logic         tick,
    output logic         f100,
    output logic [1:0]   state,
    output logic [W-1:0] cnt,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAST  = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t         state_q;
    logic [W-1:0]   cnt_q;
    logic           tick_q;
    logic           f100_q;

    logic           counting;
    logic [W-1:0]   lim_m1;
    logic           wrap;

    // Counting and the wrap limit follow the state held before the edge,
    // so a transition edge still counts with the old state's rules.
    // Using >= lets a counter already past FAST_DIV-1 wrap on the first
    // FAST edge instead of running on toward DIV.
    always_comb begin
        counting = (state_q == RUN) || (state_q == FAST);
        lim_m1   = (state_q == FAST) ? W'(FAST_DIV - 1) : W'(DIV - 1);
        wrap     = counting && (cnt_q >= lim_m1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            f100_q  <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            f100_q  <= 1'b0;
        end else begin
            tick_q <= wrap;
            if (wrap) begin
                cnt_q  <= '0;
                f100_q <= ~f100_q;
            end else if (counting) begin
                cnt_q <= cnt_q + W'(1);
            end

            case (state_q)
                IDLE:  if (run) state_q <= RUN;
                RUN:   if (!run) state_q <= PAUSE;
                       else if (fast) state_q <= FAST;
                FAST:  if (!run) state_q <= PAUSE;
                       else if (!fast) state_q <= RUN;
                PAUSE: if (run) state_q <= fast ? FAST : RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tick  = tick_q;
    assign f100  = f100_q;
    assign state = state_q;
    assign cnt   = cnt_q;
    assign busy  = (state_q == RUN) || (state_q == FAST);

endmodule

// File: tb/tb_tb_sched.sv
// Directed bench for tb_sched: small instance (DIV=8, FAST_DIV=3) for the
// control scenarios, default instance for the long-run tick count.
module tb_tb_sched;

    logic       clk = 1'b0;
    logic       rst, run, fast, clr;
    logic       tick, f100, busy;
    logic [1:0] state;
    logic [3:0] cnt;

    logic       rst6, run6;
    logic       tick6, f1006, busy6;
    logic [1:0] state6;
    logic [9:0] cnt6;

    int nchk = 0;
    int nerr = 0;
    logic exp_f = 1'b0;

    always #5 clk = ~clk;

    tb_sched #(.DIV(8), .FAST_DIV(3), .W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .fast(fast), .clr(clr),
        .tick(tick), .f100(f100), .state(state), .cnt(cnt), .busy(busy)
    );

    tb_sched dut6 (
        .clk(clk), .rst(rst6), .run(run6), .fast(1'b0), .clr(1'b0),
        .tick(tick6), .f100(f1006), .state(state6), .cnt(cnt6), .busy(busy6)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n edges; tick expected on edge index first, first+per, ... (1-based)
    task automatic expect_ticks(input string tag, input int n, input int first, input int per);
        for (int i = 1; i <= n; i++) begin
            logic e;
            step();
            e = (i >= first) && ((i - first) % per == 0);
            if (e) exp_f = ~exp_f;
            chk({tag, "_tick"}, int'(tick), int'(e));
            chk({tag, "_f100"}, int'(f100), int'(exp_f));
        end
    endtask

    initial begin
        int nt, nf;
        logic pf;
        rst = 1'b1; run = 1'b0; fast = 1'b0; clr = 1'b0;
        rst6 = 1'b1; run6 = 1'b0;
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_cnt",   int'(cnt), 0);
        chk("rst_tick",  int'(tick), 0);
        chk("rst_f100",  int'(f100), 0);
        chk("rst_busy",  int'(busy), 0);

        // Scenario 1: run held from IDLE
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b1;
        step();
        chk("s1_state", int'(state), 1);
        chk("s1_cnt",   int'(cnt), 0);
        chk("s1_tick",  int'(tick), 0);
        chk("s1_busy",  int'(busy), 1);
        expect_ticks("s1", 24, 8, 8);        // ticks at edges 9, 17, 25
        chk("s1_cnt_end", int'(cnt), 0);

        // Scenario 2: fast entered at cnt=5
        expect_ticks("s2a", 5, 99, 1);
        chk("s2_cnt5", int'(cnt), 5);
        fast = 1'b1;
        expect_ticks("s2f", 8, 2, 3);        // 6 -> wrap, then every 3
        chk("s2_state_fast", int'(state), 2);
        fast = 1'b0;
        expect_ticks("s2r", 16, 8, 8);
        chk("s2_state_run", int'(state), 1);
        chk("s2_cnt_end", int'(cnt), 0);

        // Scenario 3: pause at cnt=4
        expect_ticks("s3a", 3, 99, 1);
        run = 1'b0;
        step();                              // RUN edge still counts 3 -> 4
        chk("s3_state_pause", int'(state), 3);
        chk("s3_cnt4", int'(cnt), 4);
        chk("s3_busy", int'(busy), 0);
        expect_ticks("s3p", 20, 99, 1);
        chk("s3_cnt_hold", int'(cnt), 4);
        run = 1'b1;
        step();                              // PAUSE edge does not count
        chk("s3_state_run", int'(state), 1);
        chk("s3_cnt_resume", int'(cnt), 4);
        expect_ticks("s3r", 4, 4, 8);        // 5, 6, 7, wrap
        chk("s3_cnt_end", int'(cnt), 0);

        // Scenario 4: clr with run high at cnt=6
        expect_ticks("s4a", 6, 99, 1);
        chk("s4_cnt6", int'(cnt), 6);
        clr = 1'b1;
        step();
        exp_f = 1'b0;
        chk("s4_state", int'(state), 0);
        chk("s4_cnt",   int'(cnt), 0);
        chk("s4_tick",  int'(tick), 0);
        chk("s4_f100",  int'(f100), 0);
        clr = 1'b0;
        step();
        chk("s4_state_run", int'(state), 1);
        chk("s4_cnt_run",   int'(cnt), 0);
        expect_ticks("s4r", 8, 8, 8);

        // Scenario 5: async reset mid-count, fast with run low
        expect_ticks("s5a", 3, 99, 1);
        chk("s5_cnt3", int'(cnt), 3);
        #3 rst = 1'b1;
        #1;
        exp_f = 1'b0;
        chk("s5_state", int'(state), 0);
        chk("s5_cnt",   int'(cnt), 0);
        chk("s5_tick",  int'(tick), 0);
        chk("s5_f100",  int'(f100), 0);
        chk("s5_busy",  int'(busy), 0);
        run = 1'b0; fast = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("s5_fast_norun", int'(state), 0);
        step();
        chk("s5_fast_norun2", int'(state), 0);
        chk("s5_cnt_idle", int'(cnt), 0);
        fast = 1'b0; run = 1'b1;
        step();
        chk("s5_resume_state", int'(state), 1);
        chk("s5_resume_tick", int'(tick), 0);

        // Scenario 6: default parameters, 10000 edges
        @(posedge clk); #1;
        rst6 = 1'b0; run6 = 1'b1;
        nt = 0; nf = 0; pf = f1006;
        for (int i = 1; i <= 10000; i++) begin
            step();
            if (tick6) nt++;
            if (f1006 != pf) nf++;
            pf = f1006;
        end
        chk("s6_ticks",   nt, 9);
        chk("s6_toggles", nf, 9);
        chk("s6_cnt",     int'(cnt6), 999);
        step();
        chk("s6_tick_10001", int'(tick6), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
